ahb2apb: RTL and testbench

AHB-Lite slave to APB4 master bridge, the return path to the existing APB-to-AHB bridge. Lets on-chip AHB masters reach APB peripherals in the programmable-logic fabric. The AHB and APB sides share one clock, apb_clock. The bridge handles one transfer at a time, holds AHB with hreadyout low while the APB access runs, and maps APB errors to the two-cycle AHB ERROR response.

---
 rtl/ahb2apb_pkg.sv | 25 ++
 rtl/ahb2apb_if.sv | 51 +++++
 rtl/ahb2apb_strb.sv | 34 +++
 rtl/ahb2apb.sv | 116 +++++++++++
 tb/tb_ahb2apb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge.
// Contents: HTRANS / HSIZE / HRESP encodings and the bridge FSM state type.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

endpackage

// File: rtl/ahb2apb_if.sv
// AHB-Lite slave side and APB4 master side of the bridge, bundled as one bus.
// slave  : seen from the bridge (samples AHB requests and APB responses,
//          drives AHB responses and APB requests).
// master : seen from the surrounding system (AHB master plus APB peripheral).
interface ahb2apb_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
);
  logic                 ahb_hsel;
  logic [1:0]           ahb_htrans;
  logic                 ahb_hready;
  logic                 ahb_hwrite;
  logic [ADDR_BITS-1:0] ahb_haddr;
  logic [2:0]           ahb_hsize;
  logic [2:0]           ahb_hburst;
  logic [3:0]           ahb_hprot;
  logic                 ahb_hmastlock;
  logic [DATA_BITS-1:0] ahb_hwdata;
  logic                 ahb_hreadyout;
  logic                 ahb_hresp;
  logic [DATA_BITS-1:0] ahb_hrdata;

  logic                 apb_psel;
  logic                 apb_penable;
  logic                 apb_pwrite;
  logic [ADDR_BITS-1:0] apb_paddr;
  logic [DATA_BITS-1:0] apb_pwdata;
  logic [3:0]           apb_pstrb;
  logic [2:0]           apb_pprot;
  logic                 apb_pready;
  logic                 apb_pslverr;
  logic [DATA_BITS-1:0] apb_prdata;

  modport slave (
    input  ahb_hsel, ahb_htrans, ahb_hready, ahb_hwrite, ahb_haddr, ahb_hsize,
           ahb_hburst, ahb_hprot, ahb_hmastlock, ahb_hwdata,
           apb_pready, apb_pslverr, apb_prdata,
    output ahb_hreadyout, ahb_hresp, ahb_hrdata,
           apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
           apb_pstrb, apb_pprot
  );

  modport master (
    output ahb_hsel, ahb_htrans, ahb_hready, ahb_hwrite, ahb_haddr, ahb_hsize,
           ahb_hburst, ahb_hprot, ahb_hmastlock, ahb_hwdata,
           apb_pready, apb_pslverr, apb_prdata,
    input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
           apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
           apb_pstrb, apb_pprot
  );
endinterface

// File: rtl/ahb2apb_strb.sv
// Byte-strobe and size/alignment decode for one AHB address phase.
// Inputs : hsize, addr_lo (haddr[1:0]), hwrite
// Outputs: pstrb (all zero on reads), misalign_err (unsupported size or
//          address not aligned to the transfer size)
module ahb2apb_strb
  import ahb_apb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] pstrb,
  output logic       misalign_err
);

  always_comb begin
    pstrb        = 4'b0000;
    misalign_err = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        if (hwrite) pstrb = 4'(4'b0001 << addr_lo);
      end
      HSIZE_HALF: begin
        misalign_err = addr_lo[0];
        if (hwrite) pstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        misalign_err = (addr_lo != 2'b00);
        if (hwrite) pstrb = 4'b1111;
      end
      default: misalign_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb2apb.sv
// AHB-Lite slave to APB4 master bridge, one transfer in flight at a time.
// Ports: reset (async, active-high), apb_clock (shared by both buses),
//        bus (ahb2apb_if.slave: AHB request/response, APB request/response).
// AHB is stalled with hreadyout low during SETUP/ACCESS; APB errors and
// bad size/alignment produce the two-cycle AHB ERROR response.
module ahb2apb
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic       reset,
  input  logic       apb_clock,
  ahb2apb_if.slave   bus
);

  bridge_state_e        state_q, state_d;
  logic                 accept, size_err, load_req, load_rdata;
  logic [3:0]           strb;
  logic                 hreadyout_q, hresp_q, psel_q, penable_q, pwrite_q;
  logic [ADDR_BITS-1:0] paddr_q;
  logic [3:0]           pstrb_q;
  logic [2:0]           pprot_q;
  logic [DATA_BITS-1:0] hrdata_q;
  logic                 unused_ok;

  // Burst type, lock and the cacheable/bufferable hprot bits have no APB meaning.
  assign unused_ok = ^{bus.ahb_hburst, bus.ahb_hmastlock, bus.ahb_hprot[3:2]};

  assign accept = bus.ahb_hsel & bus.ahb_hready &
                  ((bus.ahb_htrans == HTRANS_NONSEQ) | (bus.ahb_htrans == HTRANS_SEQ));

  ahb2apb_strb u_strb (
    .hsize        (bus.ahb_hsize),
    .addr_lo      (bus.ahb_haddr[1:0]),
    .hwrite       (bus.ahb_hwrite),
    .pstrb        (strb),
    .misalign_err (size_err)
  );

  // State register.
  always_ff @(posedge apb_clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus load enables for the request and read-data registers.
  always_comb begin
    state_d    = state_q;
    load_req   = 1'b0;
    load_rdata = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          load_req = 1'b1;
          state_d  = size_err ? ST_ERR1 : ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.apb_pready) begin
          if (bus.apb_pslverr) begin
            state_d = ST_ERR1;
          end else begin
            state_d    = ST_IDLE;
            load_rdata = ~pwrite_q;
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs registered from the next state so they line up with it.
  always_ff @(posedge apb_clock or posedge reset) begin
    if (reset) begin
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pstrb_q     <= 4'b0000;
      pprot_q     <= 3'b000;
      hrdata_q    <= '0;
    end else begin
      hreadyout_q <= !(state_d inside {ST_SETUP, ST_ACCESS, ST_ERR1});
      hresp_q     <= (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
      psel_q      <= state_d inside {ST_SETUP, ST_ACCESS};
      penable_q   <= (state_d == ST_ACCESS);
      if (load_req) begin
        pwrite_q <= bus.ahb_hwrite;
        paddr_q  <= bus.ahb_haddr;
        pstrb_q  <= strb;
        pprot_q  <= {~bus.ahb_hprot[0], 1'b0, bus.ahb_hprot[1]};
      end
      if (load_rdata) hrdata_q <= bus.apb_prdata;
    end
  end

  assign bus.ahb_hreadyout = hreadyout_q;
  assign bus.ahb_hresp     = hresp_q;
  assign bus.ahb_hrdata    = hrdata_q;
  assign bus.apb_psel      = psel_q;
  assign bus.apb_penable   = penable_q;
  assign bus.apb_pwrite    = pwrite_q;
  assign bus.apb_paddr     = paddr_q;
  assign bus.apb_pstrb     = pstrb_q;
  assign bus.apb_pprot     = pprot_q;
  // Write data is held steady by the stalled AHB data phase.
  assign bus.apb_pwdata    = bus.ahb_hwdata;

endmodule

// File: tb/tb_ahb2apb.sv
// Self-checking bench for ahb2apb: directed cases plus randomized transfers
// against a transaction-level model (expected strobes, protection, latency,
// response and read data computed from the bus rules).
module tb_ahb2apb;
  import ahb_apb_pkg::*;

  logic apb_clock = 1'b0;
  logic reset;
  logic hready_block;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] exp_hrdata;
  int   cyc_cnt = 0, last_rise = 0, prev_rise = 0;
  logic psel_prev = 1'b0;

  always #5 apb_clock = ~apb_clock;

  ahb2apb_if bus ();
  assign bus.ahb_hready = bus.ahb_hreadyout & ~hready_block;

  ahb2apb dut (
    .reset     (reset),
    .apb_clock (apb_clock),
    .bus       (bus.slave)
  );

  // psel rising-edge tracker, sampled on the falling edge
  always @(negedge apb_clock) begin
    cyc_cnt   <= cyc_cnt + 1;
    psel_prev <= bus.apb_psel;
    if (bus.apb_psel && !psel_prev) begin
      prev_rise <= last_rise;
      last_rise <= cyc_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: transfer-level rules.
  function automatic logic model_size_err(input logic [2:0] size, input logic [31:0] addr);
    int nbytes;
    if (size > 3'd2) return 1'b1;
    nbytes = 1 << size;
    return (int'(addr[1:0]) % nbytes) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic write, input logic [2:0] size,
                                            input logic [31:0] addr);
    int nbytes, mask;
    if (!write) return 4'b0000;
    nbytes = 1 << size;
    mask   = ((1 << nbytes) - 1) << int'(addr[1:0]);
    return mask[3:0];
  endfunction

  function automatic logic [2:0] model_pprot(input logic [3:0] hprot);
    logic privileged, instruction;
    privileged  = hprot[1];
    instruction = !hprot[0];
    return {instruction, 1'b0, privileged};
  endfunction

  // One non-accepted cycle: deselected, BUSY, IDLE, or NONSEQ with hready low.
  task automatic idle_cycle(input int kind);
    bus.ahb_hsel   = (kind != 0);
    bus.ahb_htrans = (kind == 1) ? HTRANS_BUSY : (kind == 2) ? HTRANS_IDLE : HTRANS_NONSEQ;
    bus.ahb_haddr  = 32'h4000_0000;
    bus.ahb_hsize  = HSIZE_WORD;
    hready_block   = (kind == 3);
    @(posedge apb_clock);
    @(negedge apb_clock);
    hready_block   = 1'b0;
    bus.ahb_hsel   = 1'b0;
    bus.ahb_htrans = HTRANS_IDLE;
    check($sformatf("idle%0d_psel", kind), 32'(bus.apb_psel), 32'd0);
    check($sformatf("idle%0d_ready", kind), 32'(bus.ahb_hreadyout), 32'd1);
    check($sformatf("idle%0d_resp", kind), 32'(bus.ahb_hresp), 32'd0);
  endtask

  // Full AHB transfer with an APB peripheral answering after 'waits' cycles.
  // Starts and ends on a falling edge where hreadyout is high.
  task automatic xfer(input string tag, input logic write, input logic [31:0] addr,
                      input logic [2:0] size, input logic [3:0] prot,
                      input logic [31:0] wdata, input int waits, input logic slverr,
                      input logic [31:0] rdata);
    logic err, done, resp_last, cap_write;
    int low, first_psel, first_pen, access_n, unstable, cyc, exp_low;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic [2:0]  cap_prot;
    err = model_size_err(size, addr);
    cap_write = 1'b0; cap_addr = '0; cap_wdata = '0; cap_strb = '0; cap_prot = '0;
    check({tag, "_ready_in"}, 32'(bus.ahb_hreadyout), 32'd1);
    bus.ahb_hsel      = 1'b1;
    bus.ahb_htrans    = HTRANS_NONSEQ;
    bus.ahb_hwrite    = write;
    bus.ahb_haddr     = addr;
    bus.ahb_hsize     = size;
    bus.ahb_hprot     = prot;
    bus.ahb_hburst    = 3'($urandom);
    bus.ahb_hmastlock = 1'b0;
    bus.apb_pready    = 1'b0;
    @(posedge apb_clock);
    @(negedge apb_clock);
    bus.ahb_hsel   = 1'b0;
    bus.ahb_htrans = HTRANS_IDLE;
    bus.ahb_haddr  = $urandom;
    bus.ahb_hwdata = wdata;
    low = 0; first_psel = -1; first_pen = -1; access_n = 0; unstable = 0;
    cyc = 1; done = 1'b0; resp_last = 1'b0;
    while (!done && cyc <= 40) begin
      if (bus.apb_psel && first_psel < 0) begin
        first_psel = cyc;
        cap_addr = bus.apb_paddr; cap_write = bus.apb_pwrite; cap_strb = bus.apb_pstrb;
        cap_prot = bus.apb_pprot; cap_wdata = bus.apb_pwdata;
      end
      if (bus.apb_psel && bus.apb_penable) begin
        if (first_pen < 0) first_pen = cyc;
        if (bus.apb_paddr !== cap_addr || bus.apb_pwrite !== cap_write ||
            bus.apb_pstrb !== cap_strb || bus.apb_pprot !== cap_prot ||
            bus.apb_pwdata !== cap_wdata) unstable++;
        bus.apb_pready  = (access_n == waits);
        bus.apb_pslverr = bus.apb_pready ? slverr : 1'($urandom);
        bus.apb_prdata  = bus.apb_pready ? rdata : $urandom;
        access_n++;
      end else begin
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'($urandom);
        bus.apb_prdata  = $urandom;
      end
      if (bus.ahb_hreadyout) begin
        done = 1'b1;
      end else begin
        low++;
        resp_last = bus.ahb_hresp;
        @(posedge apb_clock);
        @(negedge apb_clock);
        cyc++;
      end
    end
    bus.apb_pready = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    exp_low = err ? 1 : 2 + waits + (slverr ? 1 : 0);
    check({tag, "_wait_cycles"}, 32'(low), 32'(exp_low));
    check({tag, "_hresp_low"}, 32'(resp_last), 32'(err || slverr));
    check({tag, "_hresp_end"}, 32'(bus.ahb_hresp), 32'(err || slverr));
    if (err) begin
      check({tag, "_no_psel"}, 32'(first_psel), 32'hFFFF_FFFF);
    end else begin
      check({tag, "_psel_at"}, 32'(first_psel), 32'd1);
      check({tag, "_penable_at"}, 32'(first_pen), 32'd2);
      check({tag, "_paddr"}, cap_addr, addr);
      check({tag, "_pwrite"}, 32'(cap_write), 32'(write));
      check({tag, "_pstrb"}, 32'(cap_strb), 32'(model_strb(write, size, addr)));
      check({tag, "_pprot"}, 32'(cap_prot), 32'(model_pprot(prot)));
      if (write) check({tag, "_pwdata"}, cap_wdata, wdata);
      check({tag, "_stable"}, 32'(unstable), 32'd0);
      if (!slverr && !write) exp_hrdata = rdata;
    end
    check({tag, "_hrdata"}, bus.ahb_hrdata, exp_hrdata);
  endtask

  initial begin
    logic [2:0]  rsize;
    logic [31:0] raddr;
    reset = 1'b1;
    hready_block = 1'b0;
    bus.ahb_hsel = 1'b0; bus.ahb_htrans = HTRANS_IDLE; bus.ahb_hwrite = 1'b0;
    bus.ahb_haddr = '0; bus.ahb_hsize = HSIZE_WORD; bus.ahb_hburst = 3'b000;
    bus.ahb_hprot = 4'b0011; bus.ahb_hmastlock = 1'b0; bus.ahb_hwdata = '0;
    bus.apb_pready = 1'b0; bus.apb_pslverr = 1'b0; bus.apb_prdata = '0;
    exp_hrdata = '0;
    repeat (2) @(negedge apb_clock);
    check("rst_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
    check("rst_hresp", 32'(bus.ahb_hresp), 32'd0);
    check("rst_hrdata", bus.ahb_hrdata, 32'd0);
    check("rst_psel", 32'(bus.apb_psel), 32'd0);
    check("rst_penable", 32'(bus.apb_penable), 32'd0);
    check("rst_pwrite", 32'(bus.apb_pwrite), 32'd0);
    check("rst_paddr", bus.apb_paddr, 32'd0);
    check("rst_pstrb", 32'(bus.apb_pstrb), 32'd0);
    check("rst_pprot", 32'(bus.apb_pprot), 32'd0);
    reset = 1'b0;
    @(negedge apb_clock);

    xfer("wr_word", 1'b1, 32'h4000_0010, HSIZE_WORD, 4'b0011, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    xfer("wr_byte", 1'b1, 32'h4000_0003, HSIZE_BYTE, 4'b0001, 32'h1122_3344, 0, 1'b0, 32'h0);
    xfer("wr_half", 1'b1, 32'h4000_0002, HSIZE_HALF, 4'b0010, 32'h5566_7788, 1, 1'b0, 32'h0);
    xfer("rd_byte", 1'b0, 32'h4000_0001, HSIZE_BYTE, 4'b0000, 32'h0, 0, 1'b0, 32'hA5A5_A5A5);
    xfer("rd_wait", 1'b0, 32'h4000_0040, HSIZE_WORD, 4'b0011, 32'h0, 3, 1'b0, 32'h1234_5678);
    xfer("rd_slverr", 1'b0, 32'h4000_0044, HSIZE_WORD, 4'b0011, 32'h0, 0, 1'b1, 32'hFFFF_0000);
    xfer("rd_in_err2", 1'b0, 32'h4000_0048, HSIZE_WORD, 4'b0011, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    xfer("err_align", 1'b0, 32'h4000_0002, HSIZE_WORD, 4'b0011, 32'h0, 0, 1'b0, 32'h0);
    idle_cycle(0);
    xfer("err_size", 1'b1, 32'h4000_0000, 3'd3, 4'b0011, 32'h0, 0, 1'b0, 32'h0);
    xfer("err_half", 1'b1, 32'h4000_0005, HSIZE_HALF, 4'b0011, 32'h0, 0, 1'b0, 32'h0);
    idle_cycle(1);
    idle_cycle(2);
    idle_cycle(3);

    xfer("b2b_0", 1'b0, 32'h4000_0100, HSIZE_WORD, 4'b0011, 32'h0, 0, 1'b0, 32'h0000_0001);
    xfer("b2b_1", 1'b0, 32'h4000_0104, HSIZE_WORD, 4'b0011, 32'h0, 0, 1'b0, 32'h0000_0002);
    xfer("b2b_2", 1'b0, 32'h4000_0108, HSIZE_WORD, 4'b0011, 32'h0, 0, 1'b0, 32'h0000_0003);
    @(posedge apb_clock);
    #1;
    check("b2b_psel_period", 32'(last_rise - prev_rise), 32'd3);
    @(negedge apb_clock);

    // Reset in the middle of an APB access.
    bus.ahb_hsel = 1'b1; bus.ahb_htrans = HTRANS_NONSEQ; bus.ahb_hwrite = 1'b0;
    bus.ahb_haddr = 32'h4000_0020; bus.ahb_hsize = HSIZE_WORD;
    @(posedge apb_clock);
    @(negedge apb_clock);
    bus.ahb_hsel = 1'b0; bus.ahb_htrans = HTRANS_IDLE; bus.apb_pready = 1'b0;
    @(posedge apb_clock);
    @(negedge apb_clock);
    check("mid_penable", 32'(bus.apb_penable), 32'd1);
    reset = 1'b1;
    #1;
    exp_hrdata = '0;
    check("mid_rst_psel", 32'(bus.apb_psel), 32'd0);
    check("mid_rst_penable", 32'(bus.apb_penable), 32'd0);
    check("mid_rst_ready", 32'(bus.ahb_hreadyout), 32'd1);
    check("mid_rst_hrdata", bus.ahb_hrdata, 32'd0);
    @(negedge apb_clock);
    reset = 1'b0;
    idle_cycle(0);

    for (int i = 0; i < 40; i++) begin
      int k;
      rsize = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      raddr = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
      xfer($sformatf("rnd%0d", i), 1'($urandom), raddr, rsize, 4'($urandom),
           $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom);
      k = $urandom_range(0, 5);
      if (k < 4) idle_cycle(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
